// File: rtl/nibble_serial_adder_ctrl_if.sv
// Command/result bundle for the nibble-serial adder sequencer.
// The master side is the requester and consumer. The slave side is the sequencer.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;

    modport master (
        output start_valid, op_a, op_b, cin, res_ready,
        input  start_ready, res_valid, result, cout, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, cin, res_ready,
        output start_ready, res_valid, result, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds WIDTH-bit operands four bits per cycle through one shared 4-bit adder.
// Processing starts with the least-significant nibble. The carry is chained through a register.
module adder_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    assign {o_cout, o_sum} = 5'(i_a) + 5'(i_b) + 5'(i_cin);
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       w_sum;
    logic             w_co;
    logic             w_accept;
    logic             w_last;

    adder_4bit u_add (
        .i_a    (r_a_sh[3:0]),
        .i_b    (r_b_sh[3:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_co)
    );

    assign w_accept = (r_state == S_IDLE) && bus.start_valid;
    assign w_last   = (r_cnt == CW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_next = S_RUN;
            S_RUN:   if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.res_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // The result fills from the MSB end, so after NIBBLES passes the first sum nibble sits at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= bus.op_a;
                        r_b_sh  <= bus.op_b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_result <= WIDTH'({w_sum, r_result} >> 4);
                    r_carry  <= w_co;
                    r_a_sh   <= r_a_sh >> 4;
                    r_b_sh   <= r_b_sh >> 4;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) r_cout <= w_co;
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.res_valid   = (r_state == S_DONE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.result      = r_result;
    assign bus.cout        = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for the 16-bit and 4-bit sequencers.
// Covers directed carry cases, backpressure, a mid-operation reset and random traffic.
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) b16 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(4))  b4 ();

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [16:0] q16[$];
    logic [4:0]  q4[$];
    bit          rnd_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitors sample mid-cycle. Inputs only change 1ns after a rising edge.
    always @(negedge clk) begin
        if (rst) q16.delete();
        else begin
            if (b16.start_valid && b16.start_ready)
                q16.push_back(17'(b16.op_a) + 17'(b16.op_b) + 17'(b16.cin));
            if (b16.res_valid && b16.res_ready) begin
                logic [16:0] e;
                if (q16.size() == 0) check("sb16_spurious", 32'd1, 32'd0);
                else begin
                    e = q16.pop_front();
                    check("sb16_res", {15'b0, b16.cout, b16.result}, {15'b0, e});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) q4.delete();
        else begin
            if (b4.start_valid && b4.start_ready)
                q4.push_back(5'(b4.op_a) + 5'(b4.op_b) + 5'(b4.cin));
            if (b4.res_valid && b4.res_ready) begin
                logic [4:0] e;
                if (q4.size() == 0) check("sb4_spurious", 32'd1, 32'd0);
                else begin
                    e = q4.pop_front();
                    check("sb4_res", {27'b0, b4.cout, b4.result}, {27'b0, e});
                end
            end
        end
    end

    // Directed 16-bit op. Checks latency, then holds res_ready low for `hold` cycles before completing.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input int hold);
        int t;
        logic [15:0] r0;
        logic c0;
        @(posedge clk); #1;
        b16.start_valid = 1'b1; b16.op_a = a; b16.op_b = b; b16.cin = c;
        t = 0;
        @(negedge clk);
        while (!b16.start_ready && t < 20) begin @(negedge clk); t++; end
        if (!b16.start_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        b16.start_valid = 1'b0;
        t = 0;
        @(negedge clk);
        check("busy_run", 32'(b16.busy), 32'd1);
        check("ready_run", 32'(b16.start_ready), 32'd0);
        while (!b16.res_valid && t < 40) begin @(negedge clk); t++; end
        check("latency", 32'(t), 32'd4);
        r0 = b16.result; c0 = b16.cout;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                b16.start_valid = 1'b1; b16.op_a = 16'h1111; b16.op_b = 16'h2222; b16.cin = 1'b0;
            end
            if (i == 3) b16.start_valid = 1'b0;
            @(negedge clk);
            check("bp_result", 32'(b16.result), 32'(r0));
            check("bp_cout", 32'(b16.cout), 32'(c0));
            check("bp_valid", 32'(b16.res_valid), 32'd1);
            check("bp_ready", 32'(b16.start_ready), 32'd0);
        end
        @(posedge clk); #1;
        b16.res_ready = 1'b1;
        @(posedge clk); #1;
        b16.res_ready = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(b16.start_ready), 32'd1);
        check("idle_valid", 32'(b16.res_valid), 32'd0);
    endtask

    task automatic rand16(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            b16.start_valid = 1'b1;
            b16.op_a = 16'($urandom); b16.op_b = 16'($urandom); b16.cin = 1'($urandom);
            t = 0;
            @(negedge clk);
            while (!b16.start_ready && t < 100) begin @(negedge clk); t++; end
            if (!b16.start_ready) check("rnd16_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            b16.start_valid = 1'b0;
        end
    endtask

    task automatic rand4(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            b4.start_valid = 1'b1;
            b4.op_a = 4'($urandom); b4.op_b = 4'($urandom); b4.cin = 1'($urandom);
            t = 0;
            @(negedge clk);
            while (!b4.start_ready && t < 100) begin @(negedge clk); t++; end
            if (!b4.start_ready) check("rnd4_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            b4.start_valid = 1'b0;
        end
    endtask

    initial begin
        int t;
        b16.start_valid = 1'b0; b16.op_a = '0; b16.op_b = '0; b16.cin = 1'b0; b16.res_ready = 1'b0;
        b4.start_valid  = 1'b0; b4.op_a  = '0; b4.op_b  = '0; b4.cin  = 1'b0; b4.res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(b16.start_ready), 32'd1);
        check("rst_valid", 32'(b16.res_valid), 32'd0);
        check("rst_busy", 32'(b16.busy), 32'd0);
        check("rst_result", 32'(b16.result), 32'd0);
        check("rst_cout", 32'(b16.cout), 32'd0);
        check("rst4_ready", 32'(b4.start_ready), 32'd1);

        op16(16'h1234, 16'h4321, 1'b0, 0);
        op16(16'hFFFF, 16'h0001, 1'b0, 0);
        op16(16'hFFFF, 16'h0000, 1'b1, 0);
        op16(16'h8000, 16'h8000, 1'b0, 0);
        op16(16'h0F0F, 16'h00F1, 1'b1, 6);

        // Reset after two RUN edges must discard the operation.
        @(posedge clk); #1;
        b16.start_valid = 1'b1; b16.op_a = 16'hAAAA; b16.op_b = 16'h5555; b16.cin = 1'b1;
        @(posedge clk); #1;
        b16.start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(b16.start_ready), 32'd1);
        check("mid_rst_valid", 32'(b16.res_valid), 32'd0);
        check("mid_rst_result", 32'(b16.result), 32'd0);
        check("mid_rst_busy", 32'(b16.busy), 32'd0);
        op16(16'h00FF, 16'h0001, 1'b0, 0);

        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                b16.res_ready = 1'($urandom);
                b4.res_ready  = 1'($urandom);
            end
        join_none
        @(posedge clk); #1;
        fork
            rand16(1000);
            rand4(1000);
        join
        t = 0;
        while ((q16.size() != 0 || q4.size() != 0) && t < 200) begin @(posedge clk); t++; end
        rnd_on = 1'b0;
        @(posedge clk); #2;
        b16.res_ready = 1'b1; b4.res_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain16", 32'(q16.size()), 32'd0);
        check("drain4", 32'(q4.size()), 32'd0);
        check("final16_valid", 32'(b16.res_valid), 32'd0);
        check("final4_valid", 32'(b4.res_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
